// File: rtl/db_arbiter_pkg.sv
// Shared definitions for the data-break arbiter.
// CPU major-state encodings for the break cycles, default bus widths and
// the arbiter FSM state type.
package db_arbiter_pkg;

    localparam int unsigned STATE_W = 5;

    // CPU major-state encodings for the three data-break cycles
    localparam logic [STATE_W-1:0] ST_DB0 = 5'd12;
    localparam logic [STATE_W-1:0] ST_DB1 = 5'd13;
    localparam logic [STATE_W-1:0] ST_DB2 = 5'd14;

    localparam int unsigned AW_DEF = 15;
    localparam int unsigned DW_DEF = 12;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_XFER = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/db_pick.sv
// Combinational winner selector for the data-break arbiter.
// Build option: DB_ROUND_ROBIN_EN selects round-robin search starting at ptr;
// without it, fixed priority with index 0 highest and no ptr port.
// Ports: req (pending requests), ptr (round-robin start, RR build only),
//        onehot_c / idx_c (winner), any_c (some request pending).
module db_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
`ifdef DB_ROUND_ROBIN_EN
    input  logic [IW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] onehot_c,
    output logic [IW-1:0]   idx_c,
    output logic            any_c
);

    // First pending request in search order wins
    always_comb begin
        int  j;
        logic found;
        onehot_c = '0;
        idx_c    = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
`ifdef DB_ROUND_ROBIN_EN
            j = (int'(ptr) + k) % int'(NREQ);
`else
            j = k;
`endif
            if (!found && req[j]) begin
                found       = 1'b1;
                onehot_c[j] = 1'b1;
                idx_c       = IW'(j);
            end
        end
        any_c = found;
    end

endmodule

// File: rtl/db_arbiter.sv
// Data-break (DMA) arbiter: shares the CPU data-break path between NREQ
// peripheral requesters (requester 0 is the RK8E disk).
// Build option: DB_ROUND_ROBIN_EN enables round-robin arbitration with a
// rotating pointer; default build uses fixed priority (index 0 highest).
// Ports: clk, reset (async active-low), state (CPU major state),
//        req/req_write/req_addr/req_wdata (per-requester, flattened),
//        mem_rdata (memory read bus), db_read/db_write/db_addr/db_wdata
//        (toward the state machine), gnt/done/rdata (back to requesters), busy.
module db_arbiter
    import db_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [STATE_W-1:0]   state,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 db_read,
    output logic                 db_write,
    output logic [AW-1:0]        db_addr,
    output logic [DW-1:0]        db_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic                 busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      fsm_q;
    logic [IW-1:0]   owner_q;
    logic            dir_write_q;
    logic            prev_db2_q;

    logic [NREQ-1:0] pick_onehot_c;
    logic [IW-1:0]   pick_idx_c;
    logic            pick_any_c;

`ifdef DB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr_q;

    db_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req      (req),
        .ptr      (rr_ptr_q),
        .onehot_c (pick_onehot_c),
        .idx_c    (pick_idx_c),
        .any_c    (pick_any_c)
    );

    // Pointer moves past the owner only when a break completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else if (fsm_q == ARB_DONE) begin
            rr_ptr_q <= IW'((int'(owner_q) + 1) % int'(NREQ));
        end
    end
`else
    db_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req      (req),
        .onehot_c (pick_onehot_c),
        .idx_c    (pick_idx_c),
        .any_c    (pick_any_c)
    );
`endif

    // Break sequencer: IDLE latch -> REQ until DB0 -> XFER through DB2 -> DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= ARB_IDLE;
            owner_q     <= '0;
            dir_write_q <= 1'b0;
            prev_db2_q  <= 1'b0;
            db_read     <= 1'b0;
            db_write    <= 1'b0;
            db_addr     <= '0;
            db_wdata    <= '0;
            gnt         <= '0;
            done        <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
        end else begin
            case (fsm_q)
                ARB_IDLE: begin
                    if (pick_any_c) begin
                        fsm_q       <= ARB_REQ;
                        busy        <= 1'b1;
                        owner_q     <= pick_idx_c;
                        gnt         <= pick_onehot_c;
                        dir_write_q <= req_write[pick_idx_c];
                        db_addr     <= req_addr[pick_idx_c*AW +: AW];
                        db_wdata    <= req_wdata[pick_idx_c*DW +: DW];
                    end
                end
                ARB_REQ: begin
                    if (state == ST_DB0) begin
                        // Committed: from here the owner cannot abort
                        fsm_q      <= ARB_XFER;
                        db_read    <= 1'b0;
                        db_write   <= 1'b0;
                        prev_db2_q <= 1'b0;
                    end else if (!req[owner_q]) begin
                        fsm_q    <= ARB_IDLE;
                        busy     <= 1'b0;
                        gnt      <= '0;
                        db_read  <= 1'b0;
                        db_write <= 1'b0;
                    end else begin
                        db_read  <= ~dir_write_q;
                        db_write <= dir_write_q;
                    end
                end
                ARB_XFER: begin
                    prev_db2_q <= (state == ST_DB2);
                    if ((state == ST_DB2) && !dir_write_q) begin
                        rdata <= mem_rdata;
                    end
                    // Falling edge of DB2 marks the end of the break
                    if (prev_db2_q && (state != ST_DB2)) begin
                        fsm_q <= ARB_DONE;
                        done  <= gnt;
                    end
                end
                ARB_DONE: begin
                    fsm_q <= ARB_IDLE;
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: fsm_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_db_arbiter.sv
// Self-checking bench for db_arbiter: directed scenarios plus randomized
// breaks, with the bench acting as CPU state machine and peripherals.
module tb_db_arbiter;
    import db_arbiter_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 12;
    localparam logic [STATE_W-1:0] ST_RUN = 5'd1;

    logic                clk = 1'b0;
    logic                reset;
    logic [STATE_W-1:0]  state;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_write;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [DW-1:0]       mem_rdata;
    logic                db_read;
    logic                db_write;
    logic [AW-1:0]       db_addr;
    logic [DW-1:0]       db_wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [DW-1:0]       rdata;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: per-requester payloads, last read value, rr pointer
    logic [AW-1:0] a_m [NREQ];
    logic [DW-1:0] d_m [NREQ];
    logic [DW-1:0] rd_m;
    int            ptr_m;

    db_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_rdata (mem_rdata),
        .db_read   (db_read),
        .db_write  (db_write),
        .db_addr   (db_addr),
        .db_wdata  (db_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner = first pending requester scanning upward from the pointer
    function automatic int pick_ref(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (r[(ptr + k) % int'(NREQ)]) return (ptr + k) % int'(NREQ);
        end
        return -1;
    endfunction

    task automatic pack_payloads();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_addr[i*AW +: AW]  = a_m[i];
            req_wdata[i*DW +: DW] = d_m[i];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_db_read"},  64'(db_read),  64'd0);
        chk({tag, "_db_write"}, 64'(db_write), 64'd0);
        chk({tag, "_db_addr"},  64'(db_addr),  64'd0);
        chk({tag, "_db_wdata"}, 64'(db_wdata), 64'd0);
        chk({tag, "_gnt"},      64'(gnt),      64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_rdata"},    64'(rdata),    64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
    endtask

    // One full break for requester idx; bench plays the CPU DB0/DB1/DB2 cycles
    task automatic run_break(input int idx, input bit keep_req);
        logic          w;
        logic [NREQ-1:0] oh;
        int            k;
        int            n2;
        w  = req_write[idx];
        oh = NREQ'(1) << idx;
        k  = 0;
        while (!(db_read || db_write) && k < 8) begin
            tick();
            k++;
        end
        chk("db_req_seen", 64'(db_read | db_write), 64'd1);
        chk("db_read",  64'(db_read),  64'(!w));
        chk("db_write", 64'(db_write), 64'(w));
        chk("gnt",      64'(gnt),      64'(oh));
        chk("db_addr",  64'(db_addr),  64'(a_m[idx]));
        chk("db_wdata", 64'(db_wdata), 64'(d_m[idx]));
        chk("busy",     64'(busy),     64'd1);
        state = ST_DB0;
        tick();
        chk("db_rw_drop", 64'({db_read, db_write}), 64'd0);
        state = ST_DB1;
        tick();
        n2 = int'($urandom_range(1, 3));
        for (int i = 0; i < n2; i++) begin
            state     = ST_DB2;
            mem_rdata = DW'($urandom);
            if (!w) rd_m = mem_rdata;
            tick();
            chk("done_early", 64'(done), 64'd0);
        end
        state = ST_RUN;
        tick();
        chk("done_pulse",  64'(done),     64'(oh));
        chk("rdata",       64'(rdata),    64'(rd_m));
        chk("gnt_in_done", 64'(gnt),      64'(oh));
        chk("wdata_hold",  64'(db_wdata), 64'(d_m[idx]));
        chk("addr_hold",   64'(db_addr),  64'(a_m[idx]));
`ifdef DB_ROUND_ROBIN_EN
        ptr_m = (idx + 1) % int'(NREQ);
`endif
        if (!keep_req) req = '0;
        tick();
        chk("done_clear", 64'(done), 64'd0);
        chk("gnt_clear",  64'(gnt),  64'd0);
        chk("idle_busy",  64'(busy), 64'd0);
    endtask

    initial begin
        int idx;
        int k;
        logic [NREQ-1:0] m;
        reset     = 1'b0;
        state     = ST_RUN;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        rd_m      = '0;
        ptr_m     = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            a_m[i] = '0;
            d_m[i] = '0;
        end
        repeat (2) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Stray DB0 while idle is ignored
        state = ST_DB0;
        tick();
        chk("stray_db0_busy", 64'(busy), 64'd0);
        state = ST_RUN;

        // Single read from requester 0
        a_m[0] = 15'o01234;
        d_m[0] = 12'o0000;
        pack_payloads();
        req_write = 2'b00;
        req = 2'b01;
        tick();
        chk("latch_gnt", 64'(gnt), 64'd1);
        chk("latch_no_rd", 64'(db_read), 64'd0);
        tick();
        chk("rd_asserted", 64'(db_read), 64'd1);
        state = ST_DB0; tick();
        state = ST_DB1; tick();
        state = ST_DB2; mem_rdata = 12'o4567; rd_m = 12'o4567; tick();
        state = ST_RUN; tick();
        chk("rd_done", 64'(done), 64'd1);
        chk("rd_rdata", 64'(rdata), 64'(12'o4567));
        req = '0;
        tick();
        chk("rd_gnt_clear", 64'(gnt), 64'd0);
        chk("rd_done_clear", 64'(done), 64'd0);
`ifdef DB_ROUND_ROBIN_EN
        ptr_m = 1;
`endif

        // Single write from requester 1; rdata must stay
        a_m[1] = 15'o70000;
        d_m[1] = 12'o7402;
        pack_payloads();
        req_write = 2'b10;
        req = 2'b10;
        run_break(1, 1'b0);
        chk("wr_rdata_kept", 64'(rdata), 64'(12'o4567));

        // Simultaneous requests, two consecutive breaks
        req_write = 2'b00;
        a_m[0] = 15'o00100; a_m[1] = 15'o00200;
        pack_payloads();
        req = 2'b11;
        idx = pick_ref(req, ptr_m);
        chk("sim_first_is_0", 64'(idx), 64'd0);
        run_break(idx, 1'b1);
        idx = pick_ref(req, ptr_m);
        run_break(idx, 1'b0);

        // Abort before DB0
        req_write = 2'b00;
        req = 2'b01;
        tick();
        tick();
        chk("abort_rd_up", 64'(db_read), 64'd1);
        req = '0;
        tick();
        chk("abort_rd", 64'(db_read), 64'd0);
        chk("abort_gnt", 64'(gnt), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        tick();
        chk("abort_no_done", 64'(done), 64'd0);

        // Back-to-back with req[0] held
        a_m[0] = 15'o01000;
        pack_payloads();
        req = 2'b01;
        run_break(0, 1'b1);
        tick();
        chk("b2b_latch_rd", 64'(db_read), 64'd0);
        chk("b2b_latch_gnt", 64'(gnt), 64'd1);
        tick();
        chk("b2b_rd", 64'(db_read), 64'd1);
        run_break(0, 1'b0);

        // Async reset during DB1
        req_write = 2'b00;
        req = 2'b01;
        k = 0;
        while (!db_read && k < 8) begin
            tick();
            k++;
        end
        chk("rst_pre_rd", 64'(db_read), 64'd1);
        state = ST_DB0; tick();
        state = ST_DB1;
        #2 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        rd_m  = '0;
        ptr_m = 0;
        req   = '0;
        state = ST_RUN;
        tick();
        reset = 1'b1;
        tick();
        a_m[1] = 15'o05555;
        d_m[1] = 12'o1234;
        pack_payloads();
        req_write = 2'b10;
        req = 2'b10;
        run_break(1, 1'b0);

        // Randomized breaks against the reference model
        for (int it = 0; it < 16; it++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_write = NREQ'($urandom);
            for (int i = 0; i < int'(NREQ); i++) begin
                a_m[i] = AW'($urandom);
                d_m[i] = DW'($urandom);
            end
            pack_payloads();
            req = m;
            idx = pick_ref(m, ptr_m);
            run_break(idx, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Sequences and shares the CPU data-break (DMA) path between up to NREQ peripheral requesters (RK8E disk is requester 0).
- Picks one pending requester, drives db_read/db_write plus address/data toward the CPU state machine, and tracks DB0→DB1→DB2.
- Returns read data to the winner and issues a one-cycle completion pulse.
- Sits between peripheral controllers and state_machine/memory.

Parameters:
- NREQ, 2: number of requesters (2..4).
- AW, 15: address width, 3-bit field plus 12-bit word.
- DW, 12: data width.

Ports:
- clk  in  1  system clock, about 100 MHz.
- reset  in  1  asynchronous, active-low (0 = reset).
- state  in  5  CPU major state; DB0/DB1/DB2 encodings come from the shared parameters.
- req  in  NREQ  per-requester break request, level; held until done.
- req_write  in  NREQ  1 = write memory, 0 = read memory.
- req_addr  in  NREQ*AW  flattened addresses; requester i at bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- mem_rdata  in  DW  memory read bus, valid during DB2.
- db_read  out  1  read-break request to state machine.
- db_write  out  1  write-break request to state machine.
- db_addr  out  AW  address of the current break.
- db_wdata  out  DW  write data of the current break.
- gnt  out  NREQ  one-hot owner, from latch through DONE.
- done  out  NREQ  one-cycle completion pulse to the owner.
- rdata  out  DW  captured read data, held until next read completes.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset=0): FSM to IDLE; every output 0; rr pointer 0.
- IDLE: if any req bit set, latch winner index, direction, address and wdata; set gnt; go to REQ next edge.
- REQ:
  - Assert db_read or db_write (exactly one) registered.
  - If state==DB0 → XFER and drop db_read/db_write the same edge.
  - If owner's req falls before DB0 → abort to IDLE: gnt cleared, no done pulse, pointer unchanged.
- XFER:
  - Owner's req is ignored; the break cannot be aborted once DB0 is seen.
  - On each cycle with state==DB2 and read direction, capture mem_rdata into rdata.
  - When the previous cycle was DB2 and the current one is not → DONE.
- DONE: pulse done[owner] for one cycle; clear gnt next edge; advance pointer; return to IDLE.
- New requests arriving in REQ/XFER/DONE wait; they are first sampled in IDLE.
- Latency: req rising → db_* asserted 2 edges later (IDLE latch, then REQ).
- Minimum gap between two breaks: one IDLE cycle.
- db_addr/db_wdata are stable from REQ through DONE.
- Both req_write directions present in one cycle: no conflict, since only the winner's bit is used.
- Stray state==DB0 while IDLE: ignored.
- Write breaks leave rdata unchanged.

Optional Feature:
- Macro: DB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. Search starts at the rr pointer; after DONE the pointer becomes owner+1 mod NREQ.
- Undefined: fixed priority, index 0 (RK8E) highest. The pointer register is not built.

Decomposition:
- Shared package/include: DB0/DB1/DB2 state encodings (existing parameters file), FSM encoding localparams (IDLE, REQ, XFER, DONE), AW/DW defaults.
- One sub-module: db_pick, a combinational winner selector taking req and the pointer and returning a one-hot result plus index. It isolates the macro-dependent logic.

Test Plan:
- Single read: req=01, req_write=0, addr=15'o01234, drive state DB0→DB1→DB2 with mem_rdata=12'o4567 → db_read=1 only in REQ, done[0] pulses once, rdata=12'o4567, gnt returns to 00.
- Single write: requester 1, addr=15'o70000, wdata=12'o7402 → db_write=1, db_wdata=12'o7402 stable through DONE, rdata unchanged.
- Simultaneous req=11, two consecutive breaks:
  - With DB_ROUND_ROBIN_EN: order 0 then 1.
  - Without: 0 wins both times while req[0] stays high.
- Abort: req[0] dropped in REQ before DB0 → IDLE, no done, db_read=0 next edge.
- Async reset asserted during DB1 → all outputs 0 immediately. After release, a new request is served normally.
- Back-to-back: req[0] held after done → second db_read asserts exactly 2 edges after DONE.
